debug_host_link: RTL and testbench

Host-side partner of the pipeline debug unit: accepts a one-byte debug command, transmits it as 8N1 UART on `uartTxPin`, then receives the debug unit's dump on `uartRxPin` and reassembles it into 32-bit words. Used as the synthesizable host emulator in self-checking loopback builds, and as the bench-side driver for the datapath debug interface.

---
 rtl/debug_host_link_pkg.sv | 32 +++
 rtl/debug_host_link_if.sv | 35 +++
 rtl/debug_host_link_rx.sv | 103 ++++++++++
 rtl/debug_host_link.sv | 189 ++++++++++++++++++
 tb/tb_debug_host_link.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/debug_host_link_pkg.sv
// ============================================================================
// Module  : debug_host_pkg
// Brief   : Shared state encodings and command constants for debug_host_link.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package debug_host_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_TX_START = 3'd1,
      ST_TX_DATA  = 3'd2,
      ST_TX_STOP  = 3'd3,
      ST_RX_WAIT  = 3'd4
   } host_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   localparam logic [7:0] CMD_STEP      = 8'h73;
   localparam logic [7:0] CMD_CONT      = 8'h63;
   localparam int         BITS_PER_BYTE = 8;
   localparam logic [2:0] c_BIT_IDX_LAST = 3'(BITS_PER_BYTE - 1);

endpackage

`default_nettype wire

// File: rtl/debug_host_link_if.sv
// ============================================================================
// Module  : debug_host_link_if
// Brief   : Command, serial and dump-word signals of the debug host link.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface debug_host_link_if;
   logic        cmd_valid;
   logic [7:0]  cmd_byte;
   logic        cmd_ready;
   logic        uartTxPin;
   logic        uartRxPin;
   logic        word_valid;
   logic [31:0] word_data;
   logic [7:0]  word_index;
   logic        dump_done;
   logic        timeout_err;
   logic        frame_err;
   logic        busy;

   modport master (
      output cmd_valid, cmd_byte, uartRxPin,
      input  cmd_ready, uartTxPin, word_valid, word_data, word_index,
             dump_done, timeout_err, frame_err, busy
   );

   modport slave (
      input  cmd_valid, cmd_byte, uartRxPin,
      output cmd_ready, uartTxPin, word_valid, word_data, word_index,
             dump_done, timeout_err, frame_err, busy
   );
endinterface

`default_nettype wire

// File: rtl/debug_host_link_rx.sv
// ============================================================================
// Module  : uart_byte_rx
// Brief   : Free-running 8N1 byte receiver with synchronizer and glitch filter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_byte_rx
   import debug_host_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   input  wire logic       i_rx,
   output logic            o_byte_valid,
   output logic [7:0]      o_byte_data,
   output logic            o_frame_err
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] c_HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] c_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_prev;
   rx_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit;
   logic [7:0]       r_shift;
   logic             r_valid;
   logic             r_ferr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
         r_state <= RX_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_sync1 <= i_rx;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         case (r_state)
            RX_IDLE: begin
               if (r_prev && !r_sync2) begin
                  r_state <= RX_START;
                  r_cnt   <= '0;
               end
            end
            RX_START: begin
               // Mid-start-bit recheck: a line already back high is a glitch
               if (r_cnt == c_HALF_END) begin
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_state <= r_sync2 ? RX_IDLE : RX_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (r_cnt == c_BIT_END) begin
                  r_cnt   <= '0;
                  r_shift <= {r_sync2, r_shift[7:1]};
                  if (r_bit == c_BIT_IDX_LAST) begin
                     r_state <= RX_STOP;
                  end else begin
                     r_bit <= r_bit + 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (r_cnt == c_BIT_END) begin
                  r_cnt   <= '0;
                  r_valid <= r_sync2;
                  r_ferr  <= !r_sync2;
                  r_state <= RX_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= RX_IDLE;
         endcase
      end
   end

   assign o_byte_valid = r_valid;
   assign o_byte_data  = r_shift;
   assign o_frame_err  = r_ferr;

endmodule

`default_nettype wire

// File: rtl/debug_host_link.sv
// ============================================================================
// Module  : debug_host_link
// Brief   : Sends one 8N1 debug command, then reassembles the 32-bit dump.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_host_link
   import debug_host_pkg::*;
#(
   parameter int CLKS_PER_BIT   = 434,
   parameter int DUMP_WORDS     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  wire logic          clock,
   input  wire logic          resetGral,
   debug_host_link_if.slave   bus
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] c_BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [TO_W-1:0]  c_TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]       c_WORD_LAST = 8'((DUMP_WORDS > 0) ? DUMP_WORDS - 1 : 0);

   host_state_t      r_state;
   logic [CNT_W-1:0] r_clk_cnt;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_tx_shift;
   logic             r_tx;
   logic             r_cmd_ready;
   logic             r_busy;
   logic [1:0]       r_byte_cnt;
   logic [7:0]       r_word_cnt;
   logic [TO_W-1:0]  r_to_cnt;
   logic [23:0]      r_word_sr;
   logic [31:0]      r_word_data;
   logic [7:0]       r_word_index;
   logic             r_word_valid;
   logic             r_dump_done;
   logic             r_timeout_err;

   logic             w_byte_valid;
   logic [7:0]       w_byte_data;
   logic             w_frame_err;
   logic             w_bit_end;
   logic [31:0]      w_word;

   uart_byte_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk          (clock),
      .rst_n        (resetGral),
      .i_rx         (bus.uartRxPin),
      .o_byte_valid (w_byte_valid),
      .o_byte_data  (w_byte_data),
      .o_frame_err  (w_frame_err)
   );

   assign w_bit_end = (r_clk_cnt == c_BIT_END);
   assign w_word    = {r_word_sr, w_byte_data};

   always_ff @(posedge clock or negedge resetGral) begin
      if (!resetGral) begin
         r_state       <= ST_IDLE;
         r_clk_cnt     <= '0;
         r_bit_cnt     <= '0;
         r_tx_shift    <= '0;
         r_tx          <= 1'b1;
         r_cmd_ready   <= 1'b1;
         r_busy        <= 1'b0;
         r_byte_cnt    <= '0;
         r_word_cnt    <= '0;
         r_to_cnt      <= '0;
         r_word_sr     <= '0;
         r_word_data   <= '0;
         r_word_index  <= '0;
         r_word_valid  <= 1'b0;
         r_dump_done   <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_word_valid  <= 1'b0;
         r_dump_done   <= 1'b0;
         r_timeout_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.cmd_valid && r_cmd_ready) begin
                  r_tx_shift  <= bus.cmd_byte;
                  r_tx        <= 1'b0;
                  r_clk_cnt   <= '0;
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= ST_TX_START;
               end
            end
            ST_TX_START: begin
               if (w_bit_end) begin
                  r_clk_cnt  <= '0;
                  r_bit_cnt  <= '0;
                  r_tx       <= r_tx_shift[0];
                  r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                  r_state    <= ST_TX_DATA;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            ST_TX_DATA: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  if (r_bit_cnt == c_BIT_IDX_LAST) begin
                     r_tx    <= 1'b1;
                     r_state <= ST_TX_STOP;
                  end else begin
                     r_tx       <= r_tx_shift[0];
                     r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                     r_bit_cnt  <= r_bit_cnt + 1'b1;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            ST_TX_STOP: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  if (DUMP_WORDS == 0) begin
                     r_dump_done <= 1'b1;
                     r_cmd_ready <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= ST_IDLE;
                  end else begin
                     r_byte_cnt <= '0;
                     r_word_cnt <= '0;
                     r_to_cnt   <= '0;
                     r_state    <= ST_RX_WAIT;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            ST_RX_WAIT: begin
               // Byte arrival takes priority over a timeout landing in the same cycle
               if (w_byte_valid) begin
                  r_to_cnt   <= '0;
                  r_word_sr  <= w_word[23:0];
                  r_byte_cnt <= r_byte_cnt + 1'b1;
                  if (r_byte_cnt == 2'd3) begin
                     r_word_valid <= 1'b1;
                     r_word_data  <= w_word;
                     r_word_index <= r_word_cnt;
                     r_word_cnt   <= r_word_cnt + 1'b1;
                     if (r_word_cnt == c_WORD_LAST) begin
                        r_dump_done <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                     end
                  end
               end else if (r_to_cnt == c_TO_LAST) begin
                  r_timeout_err <= 1'b1;
                  r_cmd_ready   <= 1'b1;
                  r_busy        <= 1'b0;
                  r_state       <= ST_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_tx        <= 1'b1;
               r_cmd_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.uartTxPin   = r_tx;
   assign bus.cmd_ready   = r_cmd_ready;
   assign bus.busy        = r_busy;
   assign bus.word_valid  = r_word_valid;
   assign bus.word_data   = r_word_data;
   assign bus.word_index  = r_word_index;
   assign bus.dump_done   = r_dump_done;
   assign bus.timeout_err = r_timeout_err;
   assign bus.frame_err   = w_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_debug_host_link.sv
// ============================================================================
// Module  : tb_debug_host_link
// Brief   : Scoreboard bench: command serialization, dump words, timeout, errors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debug_host_link;
   import debug_host_pkg::*;

   localparam int CPB = 4;
   localparam int DW  = 2;
   localparam int TO  = 200;

   logic clock     = 1'b0;
   logic resetGral = 1'b0;

   debug_host_link_if bus ();

   debug_host_link #(
      .CLKS_PER_BIT   (CPB),
      .DUMP_WORDS     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock     (clock),
      .resetGral (resetGral),
      .bus       (bus)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  idx;
      logic        done;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks   = 0;
   int   n_fail     = 0;
   int   cyc        = 0;
   int   n_ferr     = 0;
   int   n_to       = 0;
   int   t_to       = 0;
   int   t_byte_end = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Output monitor: pops the scoreboard on every word and tallies error pulses
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (resetGral) begin
            if (bus.word_valid) begin
               if (sb_q.size() == 0) begin
                  check("spurious_word_valid", 32'(bus.word_valid), 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  check("word_data", bus.word_data, e.data);
                  check("word_index", 32'(bus.word_index), 32'(e.idx));
                  check("dump_done_with_word", 32'(bus.dump_done), 32'(e.done));
               end
            end else if (bus.dump_done) begin
               check("dump_done_without_word", 32'(bus.dump_done), 32'd0);
            end
            if (bus.frame_err) n_ferr++;
            if (bus.timeout_err) begin
               n_to++;
               t_to = cyc;
            end
         end
      end
   end

   // Called at a negedge with the DUT idle; returns at the negedge after the stop bit
   task automatic send_cmd(input logic [7:0] c);
      logic exp_bit;
      bus.cmd_valid = 1'b1;
      bus.cmd_byte  = c;
      @(negedge clock);
      bus.cmd_valid = 1'b0;
      check("busy_after_accept", 32'(bus.busy), 32'd1);
      for (int i = 0; i < 10 * CPB; i++) begin
         if (i < CPB) exp_bit = 1'b0;
         else if (i >= 9 * CPB) exp_bit = 1'b1;
         else exp_bit = c[(i - CPB) / CPB];
         check($sformatf("tx_cycle_%0d", i), 32'(bus.uartTxPin), 32'(exp_bit));
         check("cmd_ready_low_during_tx", 32'(bus.cmd_ready), 32'd0);
         @(negedge clock);
      end
   endtask

   task automatic uart_send(input logic [7:0] b, input logic stop);
      bus.uartRxPin = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int k = 0; k < 8; k++) begin
         bus.uartRxPin = b[k];
         repeat (CPB) @(negedge clock);
      end
      bus.uartRxPin = stop;
      repeat (CPB) @(negedge clock);
      t_byte_end = cyc;
      bus.uartRxPin = 1'b1;
      repeat (CPB) @(negedge clock);
   endtask

   task automatic send_dump(input logic [31:0] w0, input logic [31:0] w1);
      logic [31:0] w;
      for (int i = 0; i < DW; i++) begin
         w = (i == 0) ? w0 : w1;
         sb_q.push_back('{data: w, idx: 8'(i), done: (i == DW - 1)});
         for (int j = 3; j >= 0; j--) uart_send(w[j*8 +: 8], 1'b1);
      end
   endtask

   task automatic wait_drain(input string tag);
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < 200) begin
         @(negedge clock);
         k++;
      end
      check(tag, 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      int to0;
      int f0;
      bus.cmd_valid = 1'b0;
      bus.cmd_byte  = 8'h00;
      bus.uartRxPin = 1'b1;
      resetGral     = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_tx", 32'(bus.uartTxPin), 32'd1);
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_word_valid", 32'(bus.word_valid), 32'd0);
      check("rst_dump_done", 32'(bus.dump_done), 32'd0);
      check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
      check("rst_frame_err", 32'(bus.frame_err), 32'd0);
      check("rst_word_data", bus.word_data, 32'd0);
      check("rst_word_index", 32'(bus.word_index), 32'd0);
      resetGral = 1'b1;
      repeat (2) @(negedge clock);
      check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      // Full command and two-word dump
      to0 = n_to;
      send_cmd(CMD_STEP);
      check("rx_wait_tx_idle", 32'(bus.uartTxPin), 32'd1);
      check("rx_wait_busy", 32'(bus.busy), 32'd1);
      check("rx_wait_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      send_dump(32'hDEADBEEF, 32'h01020304);
      wait_drain("dump1_drain");
      @(negedge clock);
      check("dump1_idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("dump1_idle_busy", 32'(bus.busy), 32'd0);

      // Partial dump ends in timeout
      send_cmd(CMD_CONT);
      uart_send(8'hDE, 1'b1);
      uart_send(8'hAD, 1'b1);
      uart_send(8'hBE, 1'b1);
      for (int k = 0; k < 400 && n_to == to0; k++) @(negedge clock);
      check("timeout_count", 32'(n_to - to0), 32'd1);
      check("timeout_latency_in_window",
            32'((t_to - t_byte_end) >= 199 && (t_to - t_byte_end) <= 204), 32'd1);
      @(negedge clock);
      check("timeout_idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      // Framing error byte is discarded, good bytes still form both words
      send_cmd(CMD_STEP);
      f0 = n_ferr;
      uart_send(8'h55, 1'b0);
      send_dump(32'hCAFEF00D, 32'h12345678);
      wait_drain("ferr_drain");
      check("frame_err_count", 32'(n_ferr - f0), 32'd1);

      // One-cycle low glitch is rejected
      send_cmd(CMD_CONT);
      f0 = n_ferr;
      bus.uartRxPin = 1'b0;
      @(negedge clock);
      bus.uartRxPin = 1'b1;
      repeat (3 * CPB) @(negedge clock);
      send_dump(32'hA5A55A5A, 32'h0F1E2D3C);
      wait_drain("glitch_drain");
      check("glitch_frame_err_count", 32'(n_ferr - f0), 32'd0);
      check("no_extra_timeouts", 32'(n_to - to0), 32'd1);

      // Asynchronous reset while a data bit of value 0 is on the line
      @(negedge clock);
      bus.cmd_valid = 1'b1;
      bus.cmd_byte  = CMD_STEP;
      @(negedge clock);
      bus.cmd_valid = 1'b0;
      repeat (13) @(negedge clock);
      check("pre_reset_tx_bit2", 32'(bus.uartTxPin), 32'd0);
      #1 resetGral = 1'b0;
      #1;
      check("async_rst_tx", 32'(bus.uartTxPin), 32'd1);
      check("async_rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clock);
      resetGral = 1'b1;
      @(negedge clock);
      check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("post_rst_tx", 32'(bus.uartTxPin), 32'd1);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
